pcileech_sysctl_mgr: RTL
========================

// Module: pcileech_sysctl_mgr
// PURPOSE
//  Parametrised board system-control block: cycle tick counter, power-on/button reset stretcher,
//  N-button debounce, long-press config-reload pulse, M-LED driver with per-LED modes.
//  Sits in every board top between raw pads and pcileech_com/pcileech_fifo/pcileech_pcie_a7.
//  Downstream rst stays active-high; cfg_reload feeds pcileech_fifo rst_cfg_reload.
// PARAMETERS
//  NUM_BTN          2          raw buttons, active-low pads
//  NUM_LED          2          LEDs, active-low pads
//  RST_BTN          1          button index that forces system reset
//  RELOAD_BTN       1          button index for long-press reload; may equal RST_BTN
//  DEBOUNCE_CYCLES  100000     stable cycles before debounced state flips (>=1)
//  RST_STRETCH      64         sys_rst hold cycles after last reset source released (>=1)
//  LONGPRESS_CYCLES 500000000  hold cycles before cfg_reload fires (5 s @ 100 MHz)
//  ACT_STRETCH      1000000    lit cycles after led_act pulse, ACT mode
//  BLINK_BIT        24         tickcount bit driving BLINK mode and power-on blink
//  PWRON_BIT        27         power-on blink while tickcount[63:PWRON_BIT]==0
//  PWRON_BLINK      1          1 = enable power-on blink overlay on LED 0
// PORTS
//  clk         in   1          system clock
//  rst_n       in   1          reset, synchronous, active-low
//  btn_n       in   NUM_BTN    raw async buttons, 0 = pressed
//  led_mode    in   2*NUM_LED  per-LED mode, LED i = [2i+1:2i]
//  led_act     in   NUM_LED    activity strobes, 1-cycle pulses
//  led_n       out  NUM_LED    LED pads, 0 = lit
//  btn_state   out  NUM_BTN    debounced, 1 = pressed
//  sys_rst     out  1          system reset to rest of design, active-high
//  cfg_reload  out  1          one-cycle reload pulse
//  tickcount   out  64         free-running cycle count
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): tickcount=0, btn_state=0, sys_rst=1, cfg_reload=0, led_n=all 1,
//   sync/debounce/hold/act counters 0, long-press FSM IDLE, stretch counter=RST_STRETCH.
//  Sync: btn_n through 2-FF synchroniser, inverted. Debounce per button: counter increments while
//   sync != btn_state, clears when equal; at DEBOUNCE_CYCLES-1 btn_state flips, counter clears.
//   Latency raw edge -> btn_state = 2 + DEBOUNCE_CYCLES cycles; glitches shorter than that are dropped.
//  tickcount: +1 per cycle, wraps 2^64-1 -> 0; held at 0 while btn_state[RST_BTN]==1.
//  sys_rst: stretch counter reloads to RST_STRETCH while btn_state[RST_BTN]==1, else decrements
//   to 0 (saturates). sys_rst registered = (counter != 0); after release deasserts exactly
//   RST_STRETCH cycles later. Reasserting mid-stretch reloads; no early release.
//  Long-press FSM on btn_state[RELOAD_BTN], hold counter saturating:
//   IDLE  -> HELD on press, counter=0.  HELD: release -> IDLE; counter==LONGPRESS_CYCLES-1 ->
//   FIRED with cfg_reload=1 for that one cycle.  FIRED -> IDLE on release only (one pulse per press).
//   cfg_reload fires even while sys_rst is asserted (RELOAD_BTN==RST_BTN case).
//  LED mode: 0 OFF, 1 ON, 2 BLINK (lit = tickcount[BLINK_BIT]), 3 ACT (per-LED down-counter loads
//   ACT_STRETCH on led_act, retriggerable; lit while counter != 0). Simultaneous led_act and
//   counter==1: reload wins. Power-on overlay: LED 0 lit state XORed with tickcount[BLINK_BIT]
//   while PWRON_BLINK && tickcount[63:PWRON_BIT]==0. led_n registered: 1-cycle latency.
//  Widths: every counter $clog2(limit+1) bits; parameter compares at full width, no truncation.
//  rst_n asserted mid-operation: all state returns to reset values next edge, no pulse emitted.
// STRUCTURE
//  Package pcileech_sysctl_pkg: led_mode_t enum {LED_OFF, LED_ON, LED_BLINK, LED_ACT},
//   lp_state_t enum {LP_IDLE, LP_HELD, LP_FIRED}.
//  Sub-module pcileech_sysctl_debounce (sync + debounce, one instance per button via generate).
//  Stretcher, tick counter, long-press FSM and LED driver inline in this module.
// TESTING (bench params: DEBOUNCE_CYCLES=4, RST_STRETCH=8, LONGPRESS_CYCLES=20, ACT_STRETCH=5,
//  BLINK_BIT=2, PWRON_BIT=4)
//  1 rst_n low 3 cycles then high -> sys_rst=1 exactly 8 cycles after release, led_n=2'b11 in reset, tickcount 0,1,2..
//  2 btn_n[0] 3-cycle low glitch -> btn_state stays 0; 10-cycle low -> btn_state[0]=1 6 cycles after edge.
//  3 RST_BTN held 30 cycles -> tickcount=0 throughout, cfg_reload one pulse at hold cycle 20, sys_rst drops 8 after release.
//  4 reload press released at hold 19 -> no pulse; two separate 25-cycle presses -> exactly two pulses.
//  5 led_mode=ACT, led_act at t0 and t3 -> LED lit t1..t8; BLINK -> led_n toggles every 4 cycles.
//  6 force tickcount near 2^64-1 -> wraps to 0, power-on overlay re-engages for 16 cycles on LED 0.

Source files
------------

// File: rtl/pcileech_sysctl_pkg.sv
// Shared types for the board system-control block.
package pcileech_sysctl_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_ACT   = 2'd3
  } led_mode_t;

  typedef enum logic [1:0] {
    LP_IDLE  = 2'd0,
    LP_HELD  = 2'd1,
    LP_FIRED = 2'd2
  } lp_state_t;

endpackage

// File: rtl/pcileech_sysctl_debounce.sv
// Two-flop synchroniser plus stable-count debounce for one active-low button.
module pcileech_sysctl_debounce
  import pcileech_sysctl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_state
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_state;
  logic [CNT_W-1:0] r_cnt;

  // Flip only after the synchronised level has disagreed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= ~i_btn_n;
      r_s2 <= r_s1;
      if (r_s2 != r_state) begin
        if (r_cnt == CNT_LAST) begin
          r_state <= r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/pcileech_sysctl_mgr.sv
// Board system control: tick counter, reset stretcher, button debounce,
// long-press config reload and per-LED mode driver.
module pcileech_sysctl_mgr
  import pcileech_sysctl_pkg::*;
#(
  parameter int unsigned NUM_BTN          = 2,
  parameter int unsigned NUM_LED          = 2,
  parameter int unsigned RST_BTN          = 1,
  parameter int unsigned RELOAD_BTN       = 1,
  parameter int unsigned DEBOUNCE_CYCLES  = 100000,
  parameter int unsigned RST_STRETCH      = 64,
  parameter int unsigned LONGPRESS_CYCLES = 500000000,
  parameter int unsigned ACT_STRETCH      = 1000000,
  parameter int unsigned BLINK_BIT        = 24,
  parameter int unsigned PWRON_BIT        = 27,
  parameter int unsigned PWRON_BLINK      = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_BTN-1:0]   i_btn_n,
  input  logic [2*NUM_LED-1:0] i_led_mode,
  input  logic [NUM_LED-1:0]   i_led_act,
  output logic [NUM_LED-1:0]   o_led_n,
  output logic [NUM_BTN-1:0]   o_btn_state,
  output logic                 o_sys_rst,
  output logic                 o_cfg_reload,
  output logic [63:0]          o_tickcount
);

  localparam int unsigned STR_W  = $clog2(RST_STRETCH + 1);
  localparam int unsigned HOLD_W = $clog2(LONGPRESS_CYCLES + 1);
  localparam int unsigned ACT_W  = $clog2(ACT_STRETCH + 1);
  localparam logic [STR_W-1:0]  STR_LOAD  = STR_W'(RST_STRETCH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONGPRESS_CYCLES - 1);
  localparam logic [ACT_W-1:0]  ACT_LOAD  = ACT_W'(ACT_STRETCH);

  logic [NUM_BTN-1:0]            w_btn_state;
  logic                          w_rst_btn;
  logic                          w_rel_btn;
  logic [STR_W-1:0]              w_str_next;
  logic                          w_pwron;
  logic [NUM_LED-1:0]            w_lit;
  logic [NUM_LED-1:0][ACT_W-1:0] w_act_next;

  logic [63:0]                   r_tickcount;
  logic [STR_W-1:0]              r_str_cnt;
  logic                          r_sys_rst;
  lp_state_t                     r_lp_state;
  logic [HOLD_W-1:0]             r_hold_cnt;
  logic                          r_cfg_reload;
  logic [NUM_LED-1:0][ACT_W-1:0] r_act_cnt;
  logic [NUM_LED-1:0]            r_led_n;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    pcileech_sysctl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_btn_n(i_btn_n[g]),
      .o_state(w_btn_state[g])
    );
  end

  assign w_rst_btn = w_btn_state[RST_BTN];
  assign w_rel_btn = w_btn_state[RELOAD_BTN];

  // sys_rst tracks the next stretch value so it drops exactly RST_STRETCH cycles after release.
  assign w_str_next = w_rst_btn ? STR_LOAD :
                      ((r_str_cnt != '0) ? (r_str_cnt - STR_W'(1)) : '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tickcount <= 64'd0;
      r_str_cnt   <= STR_LOAD;
      r_sys_rst   <= 1'b1;
    end else begin
      r_tickcount <= w_rst_btn ? 64'd0 : (r_tickcount + 64'd1);
      r_str_cnt   <= w_str_next;
      r_sys_rst   <= (w_str_next != '0);
    end
  end

  // Long-press: one reload pulse per press, independent of sys_rst.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lp_state   <= LP_IDLE;
      r_hold_cnt   <= '0;
      r_cfg_reload <= 1'b0;
    end else begin
      r_cfg_reload <= 1'b0;
      case (r_lp_state)
        LP_IDLE: begin
          if (w_rel_btn) begin
            r_lp_state <= LP_HELD;
            r_hold_cnt <= '0;
          end
        end
        LP_HELD: begin
          if (!w_rel_btn) begin
            r_lp_state <= LP_IDLE;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_lp_state   <= LP_FIRED;
            r_cfg_reload <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        LP_FIRED: begin
          if (!w_rel_btn) begin
            r_lp_state <= LP_IDLE;
          end
        end
        default: r_lp_state <= LP_IDLE;
      endcase
    end
  end

  assign w_pwron = (r_tickcount >> PWRON_BIT) == 64'd0;

  // ACT lit state uses the post-strobe counter so a strobe lights the LED on the next cycle.
  always_comb begin
    w_lit      = '0;
    w_act_next = r_act_cnt;
    for (int i = 0; i < int'(NUM_LED); i++) begin
      if (i_led_act[i]) begin
        w_act_next[i] = ACT_LOAD;
      end else if (r_act_cnt[i] != '0) begin
        w_act_next[i] = r_act_cnt[i] - ACT_W'(1);
      end
      case (led_mode_t'(i_led_mode[2*i +: 2]))
        LED_OFF:   w_lit[i] = 1'b0;
        LED_ON:    w_lit[i] = 1'b1;
        LED_BLINK: w_lit[i] = r_tickcount[BLINK_BIT];
        LED_ACT:   w_lit[i] = (w_act_next[i] != '0);
        default:   w_lit[i] = 1'b0;
      endcase
    end
    if ((PWRON_BLINK != 0) && w_pwron) begin
      w_lit[0] = w_lit[0] ^ r_tickcount[BLINK_BIT];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_act_cnt <= '0;
      r_led_n   <= '1;
    end else begin
      r_act_cnt <= w_act_next;
      r_led_n   <= ~w_lit;
    end
  end

  assign o_led_n      = r_led_n;
  assign o_btn_state  = w_btn_state;
  assign o_sys_rst    = r_sys_rst;
  assign o_cfg_reload = r_cfg_reload;
  assign o_tickcount  = r_tickcount;

endmodule
